// File: rtl/ppm_rx_decoder.sv
// PPM receiver: preamble pulse, then one pulse per 2T-cycle symbol (slot 0 -> 0, slot 1 -> 1), MSB first.
// Latency: rx_byte_valid 1 cycle after the 8th window closes; no backpressure, strobes are single-cycle.
module ppm_rx_decoder #(
  parameter int clk1x_freq        = 1000,
  parameter int count1x_threshold = 500000 / clk1x_freq
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        ppm_in,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic        frame_done,
  output logic        frame_error,
  output logic [15:0] byte_count,
  output logic        busy
);

  localparam int          CW         = 18;
  localparam logic [CW-1:0] T_C        = CW'(count1x_threshold);
  localparam logic [CW-1:0] SYM_LAST   = CW'(2 * count1x_threshold - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(4 * count1x_threshold - 1);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, FLUSH} state_t;

  state_t        state, state_nxt;
  logic          sync1, sync2, hist;
  logic          edge_hit;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          win_hit, win_multi, win_bit;

  logic win_close, close_one, close_none, close_multi, close_bit;
  logic byte_evt, done_evt, err_evt;

  assign edge_hit = sync2 & ~hist;

  // An edge on the closing cycle still counts toward the window being closed.
  assign win_close   = (state == DATA) && (cnt == SYM_LAST);
  assign close_one   = (win_hit ^ edge_hit) & ~win_multi;
  assign close_none  = ~win_hit & ~edge_hit;
  assign close_multi = ~close_one & ~close_none;
  assign close_bit   = win_hit ? win_bit : (cnt >= T_C);

  assign byte_evt = win_close && close_one && (bit_cnt == 4'd7);
  assign done_evt = win_close && close_none && (bit_cnt == 4'd0);
  assign err_evt  = ((state == PREAMBLE) && edge_hit)
                  || (win_close && close_multi)
                  || (win_close && close_none && (bit_cnt != 4'd0));

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (edge_hit) state_nxt = PREAMBLE;
      PREAMBLE: begin
        if (edge_hit)             state_nxt = FLUSH;
        else if (cnt == SYM_LAST) state_nxt = DATA;
      end
      DATA: begin
        if (win_close) begin
          if (close_multi)     state_nxt = FLUSH;
          else if (close_none) state_nxt = IDLE;
        end
      end
      FLUSH:    if (!edge_hit && (cnt == FLUSH_LAST)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      hist          <= 1'b0;
      cnt           <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      win_hit       <= 1'b0;
      win_multi     <= 1'b0;
      win_bit       <= 1'b0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
      byte_count    <= '0;
    end else begin
      sync1         <= ppm_in;
      sync2         <= sync1;
      hist          <= sync2;
      rx_byte_valid <= byte_evt;
      frame_done    <= done_evt;
      frame_error   <= err_evt;
      unique case (state)
        IDLE: begin
          win_hit   <= 1'b0;
          win_multi <= 1'b0;
          if (edge_hit) begin
            cnt        <= CW'(1);
            byte_count <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
          end
        end
        PREAMBLE: begin
          cnt <= (edge_hit || (cnt == SYM_LAST)) ? '0 : cnt + 1'b1;
        end
        DATA: begin
          if (win_close) begin
            cnt       <= '0;
            win_hit   <= 1'b0;
            win_multi <= 1'b0;
            if (close_one) begin
              shift_reg <= {shift_reg[6:0], close_bit};
              if (bit_cnt == 4'd7) begin
                rx_byte <= {shift_reg[6:0], close_bit};
                bit_cnt <= '0;
                if (byte_count != 16'hFFFF) byte_count <= byte_count + 16'd1;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end else begin
              bit_cnt <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (edge_hit) begin
              if (win_hit) begin
                win_multi <= 1'b1;
              end else begin
                win_hit <= 1'b1;
                win_bit <= (cnt >= T_C);
              end
            end
          end
        end
        FLUSH: begin
          if (edge_hit)                cnt <= '0;
          else if (cnt == FLUSH_LAST)  cnt <= '0;
          else                         cnt <= cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ppm_rx_decoder.sv
// Directed bench for ppm_rx_decoder with T=10 (20-cycle symbols); strobes are logged by a negedge monitor.
module tb_ppm_rx_decoder;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ppm_in   = 1'b0;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid, frame_done, frame_error, busy;
  logic [15:0] byte_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;

  logic [7:0] byte_q[$];
  int         vcyc_q[$];
  int         done_n, done_cyc, err_n, err_cyc, overlap_n;
  logic       err_busy;

  ppm_rx_decoder #(.count1x_threshold(10)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset_n       (reset_n),
    .ppm_in        (ppm_in),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .frame_done    (frame_done),
    .frame_error   (frame_error),
    .byte_count    (byte_count),
    .busy          (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc = cyc + 1;

  always @(negedge CLOCK_50) begin
    if (rx_byte_valid) begin
      byte_q.push_back(rx_byte);
      vcyc_q.push_back(cyc - t0);
    end
    if (frame_done)  begin done_n++; done_cyc = cyc - t0; end
    if (frame_error) begin err_n++;  err_cyc  = cyc - t0; err_busy = busy; end
    if (int'(rx_byte_valid) + int'(frame_done) + int'(frame_error) > 1) overlap_n++;
  end

  task automatic clear_mon();
    byte_q.delete();
    vcyc_q.delete();
    done_n = 0; done_cyc = -1; err_n = 0; err_cyc = -1; overlap_n = 0; err_busy = 1'bx;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50) ppm_in = 1'b0;
  endtask

  // One 20-cycle symbol with pulses at positions p1 and p2 (-1 = none).
  task automatic sym(input int p1, input int p2 = -1);
    for (int i = 0; i < 20; i++) @(negedge CLOCK_50) ppm_in = (i == p1) || (i == p2);
  endtask

  task automatic preamble();
    @(negedge CLOCK_50) ppm_in = 1'b1;
    t0 = cyc;
    repeat (19) @(negedge CLOCK_50) ppm_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) sym(b[k] ? 10 : 0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLOCK_50);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (byte_count !== 16'h0) begin n_fail++; $display("FAIL reset_byte_count: got %h want 0000", byte_count); end
    n_tests++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte); end
    n_tests++; if ({rx_byte_valid, frame_done, frame_error} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000", {rx_byte_valid, frame_done, frame_error}); end
    reset_n = 1'b1;
    idle(5);
  endtask

  task automatic test_single_byte();
    clear_mon();
    preamble();
    send_byte(8'hA5);
    idle(30);
    n_tests++; if (byte_q.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", byte_q.size()); end
    n_tests++; if ((byte_q.size() > 0 ? byte_q[0] : 8'hxx) !== 8'hA5) begin
      n_fail++; $display("FAIL single_value: got %h want a5", byte_q.size() > 0 ? byte_q[0] : 8'hxx); end
    n_tests++; if ((vcyc_q.size() > 0 ? vcyc_q[0] : -1) !== 182) begin
      n_fail++; $display("FAIL single_latency: got %0d want 182", vcyc_q.size() > 0 ? vcyc_q[0] : -1); end
    n_tests++; if (done_n !== 1 || done_cyc !== 202) begin
      n_fail++; $display("FAIL single_done: got n=%0d at %0d want n=1 at 202", done_n, done_cyc); end
    n_tests++; if (err_n !== 0) begin n_fail++; $display("FAIL single_error: got %0d want 0", err_n); end
    n_tests++; if (byte_count !== 16'd1) begin n_fail++; $display("FAIL single_byte_count: got %0d want 1", byte_count); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[3];
    exp_b = '{8'h00, 8'hFF, 8'h3C};
    clear_mon();
    preamble();
    for (int k = 0; k < 3; k++) send_byte(exp_b[k]);
    idle(30);
    n_tests++; if (byte_q.size() !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", byte_q.size()); end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (k >= byte_q.size() || byte_q[k] !== exp_b[k] || vcyc_q[k] !== 182 + 160 * k) begin
        n_fail++;
        $display("FAIL b2b_byte%0d: got %h at %0d want %h at %0d", k,
                 k < byte_q.size() ? byte_q[k] : 8'hxx, k < vcyc_q.size() ? vcyc_q[k] : -1,
                 exp_b[k], 182 + 160 * k);
      end
    end
    n_tests++; if (done_n !== 1 || done_cyc !== 522) begin
      n_fail++; $display("FAIL b2b_done: got n=%0d at %0d want n=1 at 522", done_n, done_cyc); end
    n_tests++; if (byte_count !== 16'd3) begin n_fail++; $display("FAIL b2b_byte_count: got %0d want 3", byte_count); end
    n_tests++; if (err_n !== 0 || overlap_n !== 0) begin
      n_fail++; $display("FAIL b2b_error: got err=%0d overlap=%0d want 0 0", err_n, overlap_n); end
  endtask

  task automatic test_truncated();
    clear_mon();
    preamble();
    sym(10); sym(0); sym(10); sym(10); sym(0);
    idle(40);
    n_tests++; if (err_n !== 1 || err_cyc !== 142) begin
      n_fail++; $display("FAIL trunc_error: got n=%0d at %0d want n=1 at 142", err_n, err_cyc); end
    n_tests++; if (err_busy !== 1'b0) begin n_fail++; $display("FAIL trunc_busy_fall: got %b want 0", err_busy); end
    n_tests++; if (byte_q.size() !== 0 || done_n !== 0) begin
      n_fail++; $display("FAIL trunc_no_byte: got bytes=%0d done=%0d want 0 0", byte_q.size(), done_n); end
    n_tests++; if (byte_count !== 16'd0) begin n_fail++; $display("FAIL trunc_byte_count: got %0d want 0", byte_count); end
  endtask

  task automatic test_flush();
    int busy_hi;
    clear_mon();
    preamble();
    sym(2, 12);
    idle(5);
    busy_hi = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 30; i++) begin
        @(negedge CLOCK_50) ppm_in = (i == 29);
        if (busy) busy_hi++;
      end
    end
    n_tests++; if (err_n !== 1 || err_cyc !== 42) begin
      n_fail++; $display("FAIL flush_error: got n=%0d at %0d want n=1 at 42", err_n, err_cyc); end
    n_tests++; if (busy_hi !== 120) begin n_fail++; $display("FAIL flush_busy_held: got %0d want 120", busy_hi); end
    busy_hi = 0;
    for (int j = 0; j < 45; j++) begin
      @(negedge CLOCK_50) ppm_in = 1'b0;
      if (busy) busy_hi++;
    end
    n_tests++; if (busy_hi !== 42) begin n_fail++; $display("FAIL flush_quiet_len: got %0d want 42", busy_hi); end
    clear_mon();
    preamble();
    send_byte(8'hA5);
    idle(30);
    n_tests++; if (byte_q.size() !== 1 || (byte_q.size() > 0 ? byte_q[0] : 8'hxx) !== 8'hA5 || done_n !== 1 || err_n !== 0) begin
      n_fail++; $display("FAIL flush_recover: got bytes=%0d first=%h done=%0d err=%0d want 1 a5 1 0",
                         byte_q.size(), byte_q.size() > 0 ? byte_q[0] : 8'hxx, done_n, err_n); end
  endtask

  task automatic test_slot_boundary();
    clear_mon();
    preamble();
    sym(9); sym(10); sym(19); sym(5); sym(10); sym(19); sym(3); sym(12);
    idle(30);
    n_tests++; if (byte_q.size() !== 1 || (byte_q.size() > 0 ? byte_q[0] : 8'hxx) !== 8'h6D) begin
      n_fail++; $display("FAIL slot_boundary: got n=%0d first=%h want 1 6d",
                         byte_q.size(), byte_q.size() > 0 ? byte_q[0] : 8'hxx); end
    n_tests++; if (done_n !== 1 || err_n !== 0) begin
      n_fail++; $display("FAIL slot_boundary_done: got done=%0d err=%0d want 1 0", done_n, err_n); end
  endtask

  task automatic test_mid_reset();
    clear_mon();
    preamble();
    sym(10); sym(0); sym(10);
    idle(7);
    @(negedge CLOCK_50) reset_n = 1'b0;
    @(negedge CLOCK_50) reset_n = 1'b1;
    n_tests++; if ({rx_byte, byte_count, busy, rx_byte_valid, frame_done, frame_error} !== 28'h0) begin
      n_fail++; $display("FAIL midreset_outputs: got rx=%h cnt=%h busy=%b stb=%b want all 0",
                         rx_byte, byte_count, busy, {rx_byte_valid, frame_done, frame_error}); end
    idle(40);
    n_tests++; if (err_n !== 0 || done_n !== 0 || byte_q.size() !== 0) begin
      n_fail++; $display("FAIL midreset_no_strobe: got err=%0d done=%0d bytes=%0d want 0 0 0",
                         err_n, done_n, byte_q.size()); end
    clear_mon();
    preamble();
    send_byte(8'h5A);
    idle(30);
    n_tests++; if (byte_q.size() !== 1 || (byte_q.size() > 0 ? byte_q[0] : 8'hxx) !== 8'h5A || done_n !== 1) begin
      n_fail++; $display("FAIL midreset_recover: got n=%0d first=%h done=%0d want 1 5a 1",
                         byte_q.size(), byte_q.size() > 0 ? byte_q[0] : 8'hxx, done_n); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_truncated();
    test_flush();
    test_slot_boundary();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ppm_rx_decoder.md
PPM_RX_DECODER -- requirements
Module: ppm_rx_decoder

Interface
REQ-001 SHALL have parameter clk1x_freq, default 1000, slot rate in 0.1 kHz units.
REQ-002 SHALL have parameter count1x_threshold, default 500000/clk1x_freq (500), slot length T in CLOCK_50 cycles; legal range 4..32767.
REQ-003 SHALL have port CLOCK_50, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, synchronous active-low reset.
REQ-005 SHALL have port ppm_in, input, 1 bit, asynchronous PPM line in the ppm_out format of the transmitter.
REQ-006 SHALL have port rx_byte, output, 8 bits, last decoded byte.
REQ-007 SHALL have port rx_byte_valid, output, 1 bit, one-cycle strobe qualifying rx_byte.
REQ-008 SHALL have port frame_done, output, 1 bit, one-cycle strobe at clean end of frame.
REQ-009 SHALL have port frame_error, output, 1 bit, one-cycle strobe on a decode error.
REQ-010 SHALL have port byte_count, output, 16 bits, bytes decoded in the current or last frame.
REQ-011 SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-012 SHALL pass ppm_in through a 2-flop synchronizer plus a history flop; edge = sync2 & ~hist; all slot positions are measured in synchronized time.
REQ-013 SHALL treat a symbol as 2T cycles: window position 0..T-1 is slot 0, T..2T-1 is slot 1; edge in slot 0 -> bit 0, edge in slot 1 -> bit 1.
REQ-014 SHALL implement states IDLE, PREAMBLE, DATA, FLUSH.
REQ-015 IDLE: on edge -> PREAMBLE with sym_cnt=1 (edge cycle is position 0), byte_count=0, bit_cnt=0.
REQ-016 PREAMBLE: lasts exactly 2T cycles from the edge; any further edge -> frame_error, FLUSH; at sym_cnt=2T-1 -> DATA with sym_cnt=0.
REQ-017 DATA: sym_cnt counts 0..2T-1 and wraps; the first edge in a window latches its bit; a second edge in the same window marks the window invalid.
REQ-018 At sym_cnt=2T-1, exactly one edge: shift bit into the shift register MSB first, bit_cnt+1; when bit_cnt reaches 8, update rx_byte, assert rx_byte_valid on the next cycle, byte_count+1, bit_cnt=0.
REQ-019 At sym_cnt=2T-1, no edge and bit_cnt=0: frame_done strobe, -> IDLE (byte_count held).
REQ-020 At sym_cnt=2T-1, no edge and bit_cnt!=0: frame_error strobe, partial byte discarded, -> IDLE.
REQ-021 At sym_cnt=2T-1, two or more edges: frame_error strobe, no byte, -> FLUSH.
REQ-022 FLUSH: counter restarts at 0 on every edge; after 4T consecutive edge-free cycles -> IDLE.
REQ-023 byte_count SHALL saturate at 16'hFFFF; further bytes still emit rx_byte_valid.
REQ-024 An edge coinciding with sym_cnt=2T-1 belongs to the closing window (slot 1).
REQ-025 rx_byte SHALL hold its value between strobes; strobes are never asserted in the same cycle as each other except rx_byte_valid with frame_done never (frame_done requires bit_cnt=0 and no edge).
REQ-026 Decode latency: rx_byte_valid is 1 cycle after the close of the 8th bit window, independent of slot value.

Reset
REQ-027 With reset_n=0 at a clock edge: state=IDLE, rx_byte=0, rx_byte_valid=0, frame_done=0, frame_error=0, byte_count=0, busy=0, synchronizer/history flops=0, counters=0.
REQ-028 Reset mid-frame SHALL abandon the frame without any strobe; the first edge after release starts a new PREAMBLE.

Verification (count1x_threshold=10, symbol=20 cycles)
REQ-029 Preamble pulse then symbols for 8'hA5 then 20 idle cycles -> rx_byte_valid once with rx_byte=8'hA5, then frame_done, byte_count=1, frame_error never.
REQ-030 Preamble then 3 bytes 8'h00, 8'hFF, 8'h3C -> three strobes in order with those values, byte_count=3, each strobe 1 cycle after its 8th window closes.
REQ-031 Preamble then 5 bits then silence -> frame_error at close of 6th window, no rx_byte_valid, busy falls next cycle.
REQ-032 Two pulses in one data window -> frame_error, FLUSH; pulses every 30 cycles keep busy=1; after 40 quiet cycles -> IDLE and a fresh frame decodes correctly.
REQ-033 Pulse exactly at window position 9 decodes 0, at position 10 decodes 1, at 19 decodes 1.
REQ-034 reset_n low for 1 cycle in mid-byte -> all outputs 0, no strobes, next preamble decodes 8'h5A correctly.
